// File: rtl/mine_field_gen_if.sv
// Request/status bundle for mine_field_gen: the requester drives start/seed,
// the generator drives status, placement pulses and the board bitmap.
interface mine_field_gen_if #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int MINES_W = 7
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;

    logic               start;
    logic [MINES_W-1:0] total_mines;
    logic               seed_load;
    logic [15:0]        seed;
    logic               busy;
    logic               done;
    logic               err;
    logic               place_valid;
    logic [RW-1:0]      random_row;
    logic [CW-1:0]      random_col;
    logic [N-1:0]       mine_map;
    logic [MINES_W-1:0] mine_count;

    modport master (
        output start, total_mines, seed_load, seed,
        input  busy, done, err, place_valid, random_row, random_col, mine_map, mine_count
    );

    modport slave (
        input  start, total_mines, seed_load, seed,
        output busy, done, err, place_valid, random_row, random_col, mine_map, mine_count
    );
endinterface

// File: rtl/mine_field_gen.sv
// Places a requested number of distinct mines on a ROWS x COLS board using a
// free-running 16-bit LFSR; one candidate cell is tried per cycle.
module mine_field_gen #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int MINES_W = 7
) (
    input logic             clk,
    input logic             rst,
    mine_field_gen_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam logic [MINES_W-1:0] NMax = MINES_W'(N);
    localparam logic [15:0] SeedDefault = 16'hACE1;

    typedef enum logic [1:0] {StIdle, StClear, StPlace, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [MINES_W-1:0] total_q, total_d;
    logic [MINES_W-1:0] count_q, count_d;
    logic [N-1:0]       map_q, map_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               pv_q, pv_d;

    logic [RW-1:0] cand_row;
    logic [CW-1:0] cand_col;
    logic [IW-1:0] cand_idx;
    logic          cand_ok;

    assign cand_row = lfsr_q[RW-1:0];
    assign cand_col = lfsr_q[RW+CW-1:RW];
    // Index is only meaningful when the candidate is on the board; cand_ok guards it.
    assign cand_idx = IW'(int'(cand_row) * COLS + int'(cand_col));
    assign cand_ok  = (int'(cand_row) < ROWS) && (int'(cand_col) < COLS) && !map_q[cand_idx];

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        total_d = total_q;
        count_d = count_q;
        map_d   = map_q;
        row_d   = row_q;
        col_d   = col_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        pv_d    = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                // A seed load replaces this cycle's shift, so CLEAR sees the seed itself.
                if (bus.seed_load) begin
                    lfsr_d = (bus.seed == 16'h0) ? SeedDefault : bus.seed;
                end
                if (bus.start) begin
                    if (bus.total_mines > NMax) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StClear;
                        total_d = bus.total_mines;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            StClear: begin
                map_d   = '0;
                count_d = '0;
                if (total_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StPlace;
                end
            end
            StPlace: begin
                if (cand_ok) begin
                    map_d[cand_idx] = 1'b1;
                    pv_d            = 1'b1;
                    row_d           = cand_row;
                    col_d           = cand_col;
                    count_d         = count_q + MINES_W'(1);
                    if (count_d == total_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= SeedDefault;
            total_q <= '0;
            count_q <= '0;
            map_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            total_q <= total_d;
            count_q <= count_d;
            map_q   <= map_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.place_valid = pv_q;
    assign bus.random_row  = row_q;
    assign bus.random_col  = col_q;
    assign bus.mine_map    = map_q;
    assign bus.mine_count  = count_q;
endmodule
